// File: rtl/iref_pkg.sv
// Shared constants and types for the IREF power sequencer: register addresses,
// write operations and the state encodings of the sequencer and bus writer.
package iref_pkg;

   localparam int unsigned IREF_PD     = 0;
   localparam int unsigned IREF_CHARGE = 1;

   typedef enum logic [1:0] {
      PD_ON,
      CHG_HI,
      CHG_LO,
      PD_OFF
   } op_e;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_WRITE,
      SEQ_CHARGE,
      SEQ_ON
   } seq_state_e;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_ISSUE,
      WR_GAP
   } wr_state_e;

   function automatic int unsigned op_addr(op_e op);
      return (op == PD_ON || op == PD_OFF) ? IREF_PD : IREF_CHARGE;
   endfunction

   function automatic logic op_bit(op_e op);
      return (op == CHG_HI || op == PD_OFF);
   endfunction

endpackage

// File: rtl/iref_seq_if.sv
// Native IREF CPU-side write interface; the sequencer is the master.
interface iref_seq_if #(
   parameter int unsigned IREF_ADDR_W = 1,
   parameter int unsigned DATA_W      = 32
);

   logic                   m_valid;
   logic [IREF_ADDR_W-1:0] m_address;
   logic [DATA_W-1:0]      m_wdata;
   logic                   m_wstrb;
   logic                   m_ready;

   modport master (
      output m_valid,
      output m_address,
      output m_wdata,
      output m_wstrb,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_address,
      input  m_wdata,
      input  m_wstrb,
      output m_ready
   );

endinterface

// File: rtl/iref_bus_wr.sv
// Single-write initiator: holds a request until acknowledged or timed out, then
// waits for ready to fall so a stale acknowledge never completes the next write.
module iref_bus_wr
   import iref_pkg::*;
#(
   parameter int unsigned IREF_ADDR_W    = 1,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   go,
   input  logic [IREF_ADDR_W-1:0] addr,
   input  logic                   wbit,
   output logic                   ack,
   output logic                   timeout,
   iref_seq_if.master             bus
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   wr_state_e              state_q, state_d;
   logic [TW-1:0]          cnt_q, cnt_d;
   logic [IREF_ADDR_W-1:0] addr_q, addr_d;
   logic                   bit_q, bit_d;
   logic                   launch;

   // ack/timeout are pure decodes so the sequencer can chain the next write
   // into the same cycle without a combinational loop through go.
   assign ack     = (state_q == WR_GAP) && !bus.m_ready;
   assign timeout = (state_q == WR_ISSUE) && !bus.m_ready &&
                    (cnt_q == TW'(TIMEOUT_CYCLES - 1));
   assign launch  = go && ((state_q == WR_IDLE) || ack);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      bit_d   = bit_q;
      case (state_q)
         WR_ISSUE: begin
            if (bus.m_ready)  state_d = WR_GAP;
            else if (timeout) state_d = WR_IDLE;
            else              cnt_d   = cnt_q + 1'b1;
         end
         WR_GAP: begin
            if (ack) state_d = WR_IDLE;
         end
         default: state_d = WR_IDLE;
      endcase
      if (launch) begin
         state_d = WR_ISSUE;
         cnt_d   = '0;
         addr_d  = addr;
         bit_d   = wbit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WR_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         bit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         bit_q   <= bit_d;
      end
   end

   assign bus.m_valid   = (state_q == WR_ISSUE);
   assign bus.m_wstrb   = (state_q == WR_ISSUE);
   assign bus.m_address = addr_q;
   assign bus.m_wdata   = {{(DATA_W - 1){1'b0}}, bit_q};

endmodule

// File: rtl/iref_seq.sv
// IREF power sequencer: orders PD/charge writes, times the charge pulse and
// handles power-down requests that arrive mid-sequence.
module iref_seq
   import iref_pkg::*;
#(
   parameter int unsigned IREF_ADDR_W    = 1,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned CHARGE_CYCLES  = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   output logic       busy,
   output logic       on,
   output logic       done,
   output logic       err,
   iref_seq_if.master bus
);

   localparam int unsigned CW = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;

   seq_state_e state_q, state_d;
   op_e        op_q, op_d;
   logic       busy_q, busy_d, on_q, on_d, done_q, done_d, err_q, err_d;
   logic       pend_q, pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic       go, wr_ack, wr_timeout, stop_now;

   assign stop_now = pend_q || stop;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      busy_d  = busy_q;
      on_d    = on_q;
      done_d  = 1'b0;
      err_d   = err_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      go      = 1'b0;
      case (state_q)
         SEQ_IDLE, SEQ_ON: begin
            if (stop) begin
               err_d = 1'b0; on_d = 1'b0; busy_d = 1'b1;
               op_d = PD_OFF; go = 1'b1; state_d = SEQ_WRITE;
            end else if (start && state_q == SEQ_IDLE) begin
               err_d = 1'b0; busy_d = 1'b1;
               op_d = PD_ON; go = 1'b1; state_d = SEQ_WRITE;
            end
         end
         SEQ_WRITE: begin
            if (stop) pend_d = 1'b1;
            if (wr_timeout) begin
               err_d = 1'b1; busy_d = 1'b0; on_d = 1'b0; pend_d = 1'b0;
               state_d = SEQ_IDLE;
            end else if (wr_ack) begin
               // A pending stop keeps pend set through CHG_LO so PD_OFF follows.
               case (op_q)
                  PD_ON: begin
                     go = 1'b1;
                     op_d = stop_now ? PD_OFF : CHG_HI;
                     if (stop_now) pend_d = 1'b0;
                  end
                  CHG_HI: begin
                     if (stop_now) begin
                        go = 1'b1; op_d = CHG_LO;
                     end else begin
                        cnt_d = '0; state_d = SEQ_CHARGE;
                     end
                  end
                  CHG_LO: begin
                     if (stop_now) begin
                        go = 1'b1; op_d = PD_OFF; pend_d = 1'b0;
                     end else begin
                        on_d = 1'b1; done_d = 1'b1; busy_d = 1'b0;
                        state_d = SEQ_ON;
                     end
                  end
                  default: begin
                     done_d = 1'b1; busy_d = 1'b0; pend_d = 1'b0;
                     state_d = SEQ_IDLE;
                  end
               endcase
            end
         end
         default: begin
            if (stop) pend_d = 1'b1;
            if (stop_now || cnt_q == CW'(CHARGE_CYCLES - 1)) begin
               go = 1'b1; op_d = CHG_LO; state_d = SEQ_WRITE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEQ_IDLE;
         op_q    <= PD_ON;
         busy_q  <= 1'b0;
         on_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         busy_q  <= busy_d;
         on_q    <= on_d;
         done_q  <= done_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
      end
   end

   iref_bus_wr #(
      .IREF_ADDR_W    (IREF_ADDR_W),
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wr (
      .clk     (clk),
      .rst_n   (rst_n),
      .go      (go),
      .addr    (IREF_ADDR_W'(op_addr(op_d))),
      .wbit    (op_bit(op_d)),
      .ack     (wr_ack),
      .timeout (wr_timeout),
      .bus     (bus)
   );

   assign busy = busy_q;
   assign on   = on_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_iref_seq.sv
// Bench for iref_seq: behavioural IREF responder, write scoreboard, cycle table
// for power-up/power-down, and directed abort, timeout, handshake and reset runs.
module tb_iref_seq;

   logic clk, rst_n, start, stop, busy, on, done, err;

   iref_seq_if #(.IREF_ADDR_W(1), .DATA_W(32)) bus ();

   iref_seq #(
      .IREF_ADDR_W    (1),
      .DATA_W         (32),
      .CHARGE_CYCLES  (8),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .stop  (stop),
      .busy  (busy),
      .on    (on),
      .done  (done),
      .err   (err),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // IREF responder: registered ready, optional ready stretch and CHG_HI stall
   logic        ready_q, pd_q, chg_q, block_chg;
   int unsigned hold_q, hold_extra;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0; pd_q <= 1'b1; chg_q <= 1'b0; hold_q <= 0;
      end else begin
         if (bus.m_valid && ready_q) begin
            if (bus.m_address == 1'b0) pd_q  <= bus.m_wdata[0];
            else                       chg_q <= bus.m_wdata[0];
         end
         if (bus.m_valid && !(block_chg && bus.m_address == 1'b1 && bus.m_wdata[0])) begin
            ready_q <= 1'b1; hold_q <= hold_extra;
         end else if (hold_q != 0) begin
            ready_q <= 1'b1; hold_q <= hold_q - 1;
         end else begin
            ready_q <= 1'b0;
         end
      end
   end
   assign bus.m_ready = ready_q;

   int unsigned n_cmp = 0, n_mis = 0, chg_hi_cnt = 0, stale_cnt = 0, dne_err = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct packed { logic a; logic d; } wr_t;
   wr_t exp_q[$];
   wr_t e;
   logic valid_prev;

   task automatic push_wr(input logic a, input logic d);
      exp_q.push_back('{a: a, d: d});
   endtask

   // Scoreboard: every accepted write must match the next expected one
   initial begin
      valid_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            valid_prev = 1'b0;
         end else begin
            if (chg_q) chg_hi_cnt++;
            if (bus.m_valid && bus.m_ready && !valid_prev) stale_cnt++;
            if (bus.m_valid && bus.m_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_mis++;
                  $display("FAIL unexpected_write: got addr %0d data %0h, required none",
                           bus.m_address, bus.m_wdata);
               end else begin
                  e = exp_q.pop_front();
                  chk1("wr_addr", bus.m_address, e.a);
                  chk32("wr_data", bus.m_wdata, {31'b0, e.d});
                  chk1("wr_strb", bus.m_wstrb, 1'b1);
               end
            end
            valid_prev = bus.m_valid;
         end
      end
   end

   task automatic pulse(input logic s, input logic p);
      @(negedge clk); start = s; stop = p;
      @(negedge clk); start = 1'b0; stop = 1'b0;
   endtask

   task automatic observe(input int unsigned max_cyc, output int unsigned n_done,
                          output logic on_seen, output int unsigned v_chg,
                          output logic timed_out);
      n_done = 0; on_seen = 1'b0; v_chg = 0; timed_out = 1'b1;
      for (int unsigned c = 0; c < max_cyc; c++) begin
         @(posedge clk); #1;
         if (done) n_done++;
         if (on) on_seen = 1'b1;
         if (done && err) dne_err++;
         if (bus.m_valid && bus.m_address == 1'b1) v_chg++;
         if (!busy) begin timed_out = 1'b0; break; end
      end
      repeat (2) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
   endtask

   typedef struct {
      logic start, stop;
      logic busy, on, done, valid;
   } vec_t;
   vec_t tbl[28];

   int unsigned nd, vc;
   logic ons, tmo, found;

   initial begin
      // Power-up from IDLE at step 0, power-down from ON at step 22
      for (int i = 0; i < 28; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      foreach (tbl[i]) if (i == 0 || i == 1 || i == 4 || i == 5 || i == 16 || i == 17 ||
                           i == 22 || i == 23) tbl[i].valid = 1'b1;
      tbl[0].start = 1'b1;
      tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[22].stop = 1'b1;
      tbl[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold_extra = 0; block_chg = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk1("rst_busy", busy, 1'b0);   chk1("rst_on", on, 1'b0);
      chk1("rst_done", done, 1'b0);   chk1("rst_err", err, 1'b0);
      chk1("rst_valid", bus.m_valid, 1'b0);
      chk1("rst_addr", bus.m_address, 1'b0);
      chk32("rst_wdata", bus.m_wdata, 0);
      chk1("rst_wstrb", bus.m_wstrb, 1'b0);

      // Cycle-accurate power-up and power-down
      push_wr(1'b0, 1'b0); push_wr(1'b1, 1'b1); push_wr(1'b1, 1'b0); push_wr(1'b0, 1'b1);
      chg_hi_cnt = 0;
      for (int i = 0; i < 28; i++) begin
         @(negedge clk); start = tbl[i].start; stop = tbl[i].stop;
         @(posedge clk); #1;
         chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         chk1($sformatf("tbl%0d_on", i), on, tbl[i].on);
         chk1($sformatf("tbl%0d_done", i), done, tbl[i].done);
         chk1($sformatf("tbl%0d_valid", i), bus.m_valid, tbl[i].valid);
         chk1($sformatf("tbl%0d_err", i), err, 1'b0);
      end
      start = 1'b0; stop = 1'b0;
      chk32("charge_high_cycles", chg_hi_cnt, 12);
      chk1("pwrdn_pd", pd_q, 1'b1);
      chk32("tbl_queue_left", exp_q.size(), 0);

      // Stop during CHARGE (count 3): charge low first, then PD off
      push_wr(1'b0, 1'b0); push_wr(1'b1, 1'b1); push_wr(1'b1, 1'b0); push_wr(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (chg_q) begin found = 1'b1; break; end
      end
      chk1("abort_chg_rise", found, 1'b1);
      repeat (5) @(negedge clk);
      stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      observe(80, nd, ons, vc, tmo);
      chk1("abort_idle", tmo, 1'b0);
      chk32("abort_done", nd, 1);
      chk1("abort_on_seen", ons, 1'b0);
      chk1("abort_pd", pd_q, 1'b1);
      chk1("abort_chg", chg_q, 1'b0);
      chk32("abort_queue_left", exp_q.size(), 0);

      // Timeout on CHG_HI write, then a fresh start clears err
      block_chg = 1'b1;
      push_wr(1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      observe(60, nd, ons, vc, tmo);
      chk1("to_idle", tmo, 1'b0);
      chk32("to_valid_cycles", vc, 4);
      chk32("to_done", nd, 0);
      chk1("to_err", err, 1'b1);
      chk1("to_busy", busy, 1'b0);
      chk1("to_on", on, 1'b0);
      chk32("to_queue_left", exp_q.size(), 0);
      block_chg = 1'b0;
      push_wr(1'b0, 1'b0); push_wr(1'b1, 1'b1); push_wr(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      chk1("restart_err_clr", err, 1'b0);
      chk1("restart_busy", busy, 1'b1);
      observe(80, nd, ons, vc, tmo);
      chk32("restart_done", nd, 1);
      chk1("restart_on", on, 1'b1);
      push_wr(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      observe(40, nd, ons, vc, tmo);
      chk32("restart_pwrdn_done", nd, 1);

      // Stretched ready: no write may start while a stale ready is high
      hold_extra = 3;
      stale_cnt = 0;
      push_wr(1'b0, 1'b0); push_wr(1'b1, 1'b1); push_wr(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      pulse(1'b1, 1'b0);
      observe(120, nd, ons, vc, tmo);
      chk1("hs_idle", tmo, 1'b0);
      chk32("hs_done", nd, 1);
      chk1("hs_on", on, 1'b1);
      chk32("hs_stale_issue", stale_cnt, 0);
      chk32("hs_queue_left", exp_q.size(), 0);
      hold_extra = 0;
      push_wr(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      observe(40, nd, ons, vc, tmo);
      chk1("hs_pwrdn_on", on, 1'b0);

      // Asynchronous reset while a write is outstanding
      push_wr(1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      chk1("rst2_valid_before", bus.m_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk1("rst2_valid", bus.m_valid, 1'b0);
      chk1("rst2_busy", busy, 1'b0);
      chk1("rst2_on", on, 1'b0);
      chk1("rst2_err", err, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_wr(1'b0, 1'b0); push_wr(1'b1, 1'b1); push_wr(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      observe(80, nd, ons, vc, tmo);
      chk32("rst2_run_done", nd, 1);
      chk1("rst2_run_on", on, 1'b1);
      chk32("rst2_queue_left", exp_q.size(), 0);
      chk32("done_with_err", dne_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
